instr_sequencer: RTL and testbench

- Program sequencer for the 8-bit `cpu`.
- Holds a small instruction store that a host loads over a write port.
- On `start`, it issues the stored 13-bit instructions to the `cpu` `instr` input, one per clock, in order.
- After the program ends, it captures the `cpu` `result` and reports completion with a one-cycle `done` pulse. This replaces the hand-driven instruction sequence used in `tb_cpu` and is the block that sits in front of `cpu` in the top level.

---
 rtl/instr_sequencer_if.sv | 30 +++
 rtl/instr_sequencer.sv | 121 ++++++++++++
 tb/tb_instr_sequencer.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_sequencer_if.sv
// Sequencer host/cpu bundle: store write port, run control, cpu result and issue outputs.
// The master side is the host driving loads and starts; the slave side is the sequencer.
interface instr_sequencer_if #(
  parameter int AW = 4,
  parameter int IW = 13
);
  logic          load_en;
  logic [AW-1:0] load_addr;
  logic [IW-1:0] load_data;
  logic          start;
  logic [AW:0]   prog_len;
  logic          abort;
  logic [7:0]    result_in;
  logic [IW-1:0] instr_out;
  logic          instr_valid;
  logic [AW-1:0] pc;
  logic          busy;
  logic          done;
  logic [7:0]    last_result;

  modport master (
    output load_en, load_addr, load_data, start, prog_len, abort, result_in,
    input  instr_out, instr_valid, pc, busy, done, last_result
  );

  modport slave (
    input  load_en, load_addr, load_data, start, prog_len, abort, result_in,
    output instr_out, instr_valid, pc, busy, done, last_result
  );
endinterface

// File: rtl/instr_sequencer.sv
// Issues a stored program to the cpu one instruction per clock, then captures its result.
// Start-to-done is N+1 cycles for N instructions; no backpressure, the cpu takes one per clock.
module instr_sequencer #(
  parameter int AW = 4,
  parameter int IW = 13,
  parameter logic [IW-1:0] NOP_INSTR = '0
) (
  input logic             clk,
  input logic             reset,
  instr_sequencer_if.slave bus
);
  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] DEPTH_L = DEPTH[AW:0];

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [AW:0]   len_q, len_d, len_clamp;
  logic [AW-1:0] pc_q, pc_d, pc_inc;
  logic [IW-1:0] instr_q, instr_d;
  logic          valid_q, valid_d;
  logic [7:0]    last_result_q, last_result_d;
  logic [IW-1:0] store_q [DEPTH];
  logic          store_we;

  assign len_clamp = (bus.prog_len > DEPTH_L) ? DEPTH_L : bus.prog_len;
  assign pc_inc    = pc_q + 1'b1;
  assign store_we  = bus.load_en && ((state_q == S_IDLE) || (state_q == S_DONE));

  always_comb begin
    state_d       = state_q;
    len_d         = len_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    valid_d       = valid_q;
    last_result_d = last_result_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          len_d = len_clamp;
          pc_d  = '0;
          if (len_clamp != '0) begin
            state_d = S_ISSUE;
            instr_d = store_q[0];
            valid_d = 1'b1;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_ISSUE: begin
        if (bus.abort) begin
          state_d = S_IDLE;
          instr_d = NOP_INSTR;
          valid_d = 1'b0;
          pc_d    = '0;
        end else if ({1'b0, pc_q} == (len_q - 1'b1)) begin
          state_d = S_WAIT;
          instr_d = NOP_INSTR;
          valid_d = 1'b0;
        end else begin
          pc_d    = pc_inc;
          instr_d = store_q[pc_inc];
        end
      end
      S_WAIT: begin
        // The cpu registers its last result during this cycle, so it is sampled here.
        if (bus.abort) begin
          state_d = S_IDLE;
          pc_d    = '0;
        end else begin
          last_result_d = bus.result_in;
          state_d       = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      len_q         <= '0;
      pc_q          <= '0;
      instr_q       <= NOP_INSTR;
      valid_q       <= 1'b0;
      last_result_q <= '0;
    end else begin
      state_q       <= state_d;
      len_q         <= len_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      valid_q       <= valid_d;
      last_result_q <= last_result_d;
    end
  end

  // Store survives reset so a host can rerun a program without reloading it.
  always_ff @(posedge clk) begin
    if (store_we) begin
      store_q[bus.load_addr] <= bus.load_data;
    end
  end

  assign bus.instr_out   = instr_q;
  assign bus.instr_valid = valid_q;
  assign bus.pc          = pc_q;
  assign bus.busy        = (state_q == S_ISSUE) || (state_q == S_WAIT);
  assign bus.done        = (state_q == S_DONE);
  assign bus.last_result = last_result_q;
endmodule

// File: tb/tb_instr_sequencer.sv
// Randomized bench for instr_sequencer against a per-cycle expectation built from a store model.
module tb_instr_sequencer;
  localparam int AW    = 4;
  localparam int IW    = 13;
  localparam int DEPTH = 16;
  localparam int MAXC  = 24;
  localparam logic [IW-1:0] NOP = 13'd0;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  instr_sequencer_if #(.AW(AW), .IW(IW)) bus();

  instr_sequencer #(.AW(AW), .IW(IW), .NOP_INSTR(NOP)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [IW-1:0] ref_store [DEPTH];
  logic [7:0]    exp_last;

  logic [IW-1:0] c_instr [MAXC];
  logic          c_valid [MAXC];
  logic          c_busy  [MAXC];
  logic          c_done  [MAXC];
  logic [AW-1:0] c_pc    [MAXC];
  logic [7:0]    c_last  [MAXC];
  logic [7:0]    r_drv   [MAXC];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input int a, input logic [IW-1:0] d);
    bus.load_en   = 1'b1;
    bus.load_addr = a[AW-1:0];
    bus.load_data = d;
    tick();
    bus.load_en   = 1'b0;
    ref_store[a]  = d;
  endtask

  // Accepts a start, then records outputs for ncyc cycles, injecting optional side stimulus.
  task automatic run_capture(input int plen, input int ncyc, input int abort_k, input int load_k,
                             input int start_k, input bit co_load, input logic [IW-1:0] co_data);
    logic [AW:0] pl;
    pl = plen[AW:0];
    bus.start    = 1'b1;
    bus.prog_len = pl;
    if (co_load) begin
      bus.load_en   = 1'b1;
      bus.load_addr = '0;
      bus.load_data = co_data;
    end
    tick();
    bus.prog_len = 5'($urandom);
    for (int k = 0; k < ncyc; k++) begin
      if (k > 0) tick();
      bus.start   = 1'b0;
      bus.abort   = 1'b0;
      bus.load_en = 1'b0;
      c_instr[k] = bus.instr_out;
      c_valid[k] = bus.instr_valid;
      c_busy[k]  = bus.busy;
      c_done[k]  = bus.done;
      c_pc[k]    = bus.pc;
      c_last[k]  = bus.last_result;
      r_drv[k]   = 8'($urandom_range(1, 255));
      bus.result_in = r_drv[k];
      if (k == abort_k) bus.abort = 1'b1;
      if (k == load_k) begin
        bus.load_en   = 1'b1;
        bus.load_addr = 4'($urandom);
        bus.load_data = 13'($urandom);
      end
      if (k == start_k) begin
        bus.start    = 1'b1;
        bus.prog_len = 5'($urandom_range(1, 16));
      end
    end
    bus.start   = 1'b0;
    bus.abort   = 1'b0;
    bus.load_en = 1'b0;
  endtask

  // Runs one program and compares every recorded cycle with the expected issue trace.
  task automatic test_program(input string name, input int plen, input bit co_load,
                              input logic [IW-1:0] co_data, input int load_k, input int start_k);
    int L, ncyc;
    logic [IW-1:0] old0, e_instr;
    logic [7:0] e_last, new_last;
    logic e_valid, e_busy, e_done;
    L    = (plen > DEPTH) ? DEPTH : plen;
    ncyc = L + 4;
    old0 = ref_store[0];
    run_capture(plen, ncyc, -1, load_k, start_k, co_load, co_data);
    if (co_load) ref_store[0] = co_data;
    new_last = (L == 0) ? exp_last : r_drv[L];
    for (int k = 0; k < ncyc; k++) begin
      e_valid = (k < L);
      e_busy  = (L > 0) && (k <= L);
      e_done  = (L == 0) ? (k == 0) : (k == L + 1);
      e_last  = (L > 0 && k >= L + 1) ? new_last : exp_last;
      e_instr = !e_valid ? NOP : ((k == 0) ? old0 : ref_store[k]);
      n_checks++;
      if (c_valid[k] !== e_valid) begin
        n_fail++;
        $display("FAIL %s valid k=%0d got %b exp %b", name, k, c_valid[k], e_valid);
      end
      n_checks++;
      if (c_instr[k] !== e_instr) begin
        n_fail++;
        $display("FAIL %s instr k=%0d got %h exp %h", name, k, c_instr[k], e_instr);
      end
      n_checks++;
      if (c_busy[k] !== e_busy) begin
        n_fail++;
        $display("FAIL %s busy k=%0d got %b exp %b", name, k, c_busy[k], e_busy);
      end
      n_checks++;
      if (c_done[k] !== e_done) begin
        n_fail++;
        $display("FAIL %s done k=%0d got %b exp %b", name, k, c_done[k], e_done);
      end
      n_checks++;
      if (c_last[k] !== e_last) begin
        n_fail++;
        $display("FAIL %s last_result k=%0d got %h exp %h", name, k, c_last[k], e_last);
      end
      if (e_valid) begin
        n_checks++;
        if (c_pc[k] !== 4'(k)) begin
          n_fail++;
          $display("FAIL %s pc k=%0d got %0d exp %0d", name, k, c_pc[k], k);
        end
      end
    end
    exp_last = new_last;
  endtask

  task automatic test_reset();
    n_checks++;
    if ({bus.instr_out, bus.instr_valid, bus.pc, bus.busy, bus.done, bus.last_result} !== '0) begin
      n_fail++;
      $display("FAIL reset_init got instr=%h v=%b pc=%0d busy=%b done=%b last=%h exp all zero",
               bus.instr_out, bus.instr_valid, bus.pc, bus.busy, bus.done, bus.last_result);
    end
  endtask

  task automatic test_basic();
    load_word(0, 13'b1_011_000000001);
    load_word(1, 13'b1_010_000000011);
    load_word(2, 13'b0_011_010_001_000);
    test_program("basic", 3, 1'b0, NOP, -1, -1);
  endtask

  task automatic test_zero_len();
    test_program("zero_len", 0, 1'b0, NOP, -1, -1);
  endtask

  task automatic test_clamp();
    for (int a = 0; a < DEPTH; a++) load_word(a, 13'($urandom));
    test_program("clamp", 31, 1'b0, NOP, -1, -1);
    test_program("exact16", 16, 1'b0, NOP, -1, -1);
  endtask

  task automatic test_abort();
    run_capture(3, 7, 1, -1, -1, 1'b0, NOP);
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (c_valid[k] !== 1'b1 || c_instr[k] !== ref_store[k] || c_pc[k] !== 4'(k)) begin
        n_fail++;
        $display("FAIL abort_pre k=%0d got v=%b instr=%h pc=%0d exp v=1 instr=%h pc=%0d",
                 k, c_valid[k], c_instr[k], c_pc[k], ref_store[k], k);
      end
    end
    for (int k = 2; k < 7; k++) begin
      n_checks++;
      if ({c_valid[k], c_busy[k], c_done[k]} !== 3'b000 || c_instr[k] !== NOP || c_pc[k] !== '0
          || c_last[k] !== exp_last) begin
        n_fail++;
        $display("FAIL abort_post k=%0d got v=%b busy=%b done=%b instr=%h pc=%0d last=%h exp idle last=%h",
                 k, c_valid[k], c_busy[k], c_done[k], c_instr[k], c_pc[k], c_last[k], exp_last);
      end
    end
  endtask

  task automatic test_ignored();
    test_program("ign_load", 5, 1'b0, NOP, 0, 6);
    test_program("ign_rerun", 5, 1'b0, NOP, -1, -1);
    test_program("done_start", 0, 1'b0, NOP, -1, 0);
  endtask

  task automatic test_load_start();
    test_program("ldst", 2, 1'b1, 13'h1abc, -1, -1);
    test_program("ldst_rerun", 1, 1'b0, NOP, -1, -1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 3; j++) load_word(int'($urandom_range(0, DEPTH - 1)), 13'($urandom));
      test_program("random", int'($urandom_range(0, 20)), 1'($urandom), 13'($urandom),
                   int'($urandom_range(0, 1)) - 1, -1);
    end
  endtask

  task automatic test_reset_mid();
    bus.start    = 1'b1;
    bus.prog_len = 5'd8;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    #2;
    n_checks++;
    if ({bus.instr_out, bus.instr_valid, bus.pc, bus.busy, bus.done, bus.last_result} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid got instr=%h v=%b pc=%0d busy=%b done=%b last=%h exp all zero",
               bus.instr_out, bus.instr_valid, bus.pc, bus.busy, bus.done, bus.last_result);
    end
    tick();
    reset = 1'b0;
    exp_last = 8'd0;
    tick();
    test_program("reset_rerun", 8, 1'b0, NOP, -1, -1);
  endtask

  initial begin
    reset         = 1'b1;
    bus.load_en   = 1'b0;
    bus.load_addr = '0;
    bus.load_data = '0;
    bus.start     = 1'b0;
    bus.prog_len  = '0;
    bus.abort     = 1'b0;
    bus.result_in = '0;
    exp_last      = 8'd0;
    #12;
    test_reset();
    @(negedge clk);
    reset = 1'b0;
    tick();
    for (int a = 0; a < DEPTH; a++) load_word(a, 13'($urandom));
    test_basic();
    test_zero_len();
    test_clamp();
    test_abort();
    test_ignored();
    test_load_start();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
